// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control/deserialize stage.
package uart_rx_pkg;

    // Default payload width and prescaler/edge-counter bus width
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned PRESC_W_DEF    = 5;

    // Bit counter covers start + payload + parity + stop
    localparam int unsigned BIT_CNT_W      = $clog2(DATA_WIDTH_DEF + 3);

    // Supported oversampling ratios
    localparam int unsigned PRESC_8        = 8;
    localparam int unsigned PRESC_16       = 16;

    // Frame FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Bit-counter width for an arbitrary payload width
    function automatic int unsigned bit_cnt_width(input int unsigned dw);
        return $clog2(dw + 3);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter with bit-boundary (wrap) detection and bit counter.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESC_W = PRESC_W_DEF,
    parameter int unsigned BIT_W   = BIT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] prescaler,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               wrap_c
);

    // Last oversample edge of the current bit
    assign wrap_c = en && (edge_cnt == (prescaler - PRESC_W'(1)));

    // Edge counter: wraps from prescaler-1 to 0, forced to 0 on clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
        end else if (en) begin
            edge_cnt <= wrap_c ? '0 : edge_cnt + PRESC_W'(1);
        end
    end

    // Bit counter: one count per bit boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
        end else if (wrap_c) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX control and deserialize stage: start detection, bit timing,
// frame assembly and start/parity/stop checking.
// Optional break detection output is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PRESC_W    = PRESC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    prescaler,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_bit,
    output logic                  dat_sampling_en,
    output logic [PRESC_W-1:0]    edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                  break_det
`endif
);

    localparam int unsigned BCNT_W = bit_cnt_width(DATA_WIDTH);

    rx_state_e             state;
    rx_state_e             next_state;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  wrap_c;
    logic [BCNT_W-1:0]     bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_fail;
    logic                  par_mis;
    logic                  shift_en;
    logic                  par_latch;
    logic                  dv_d;
    logic                  perr_d;
    logic                  serr_d;
    logic                  glitch_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                  par_bit;
    logic                  brk_d;
`endif

    // The cycle that sees RX_IN low in IDLE is edge 0 of the start bit
    assign cnt_en  = (state != IDLE) || !RX_IN;
    assign cnt_clr = (next_state == IDLE);

    // Received parity bit versus XOR of payload adjusted for odd/even
    assign par_mis = sampled_bit ^ (^shreg) ^ par_typ;

    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W),
        .BIT_W   (BCNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (cnt_en),
        .clr       (cnt_clr),
        .prescaler (prescaler),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .wrap_c    (wrap_c)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode; all decisions taken at bit boundaries
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        par_latch  = 1'b0;
        dv_d       = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;
        glitch_d   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_d      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    next_state = START;
                end
            end
            START: begin
                if (wrap_c) begin
                    if (sampled_bit) begin
                        glitch_d   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (wrap_c) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BCNT_W'(DATA_WIDTH)) begin
                        next_state = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (wrap_c) begin
                    par_latch  = 1'b1;
                    next_state = STOP;
                end
            end
            STOP: begin
                if (wrap_c) begin
                    serr_d     = !sampled_bit;
                    perr_d     = par_fail;
                    dv_d       = sampled_bit && !par_fail;
`ifdef UART_RX_BREAK_DET_EN
                    brk_d      = (shreg == '0) && !par_bit && !sampled_bit;
`endif
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Payload shift register, LSB received first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
        end
    end

    // Parity-fail flag held from the parity boundary to the stop boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_fail <= 1'b0;
        end else if (state == IDLE) begin
            par_fail <= 1'b0;
        end else if (par_latch) begin
            par_fail <= par_mis;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    // Raw parity bit kept for break detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit <= 1'b0;
        end else if (state == IDLE) begin
            par_bit <= 1'b0;
        end else if (par_latch) begin
            par_bit <= sampled_bit;
        end
    end

    // Break strobe register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            break_det <= 1'b0;
        end else begin
            break_det <= brk_d;
        end
    end
`endif

    // Registered strobes, sampling enable and parallel output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dat_sampling_en <= 1'b0;
            data_valid      <= 1'b0;
            par_err         <= 1'b0;
            stp_err         <= 1'b0;
            strt_glitch     <= 1'b0;
            P_DATA          <= '0;
        end else begin
            dat_sampling_en <= (next_state != IDLE);
            data_valid      <= dv_d;
            par_err         <= perr_d;
            stp_err         <= serr_d;
            strt_glitch     <= glitch_d;
            if (dv_d) begin
                P_DATA <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: frames are driven bit by bit,
// expected strobes go into a scoreboard queue and are matched on output.
module tb_uart_rx_frame_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 5;
`ifdef UART_RX_BREAK_DET_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    typedef struct packed {
        logic          dv;
        logic          perr;
        logic          serr;
        logic          glitch;
        logic          brk;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RX_IN;
    logic [PW-1:0] prescaler;
    logic          par_en;
    logic          par_typ;
    logic          sampled_bit;
    logic          dat_sampling_en;
    logic [PW-1:0] edge_cnt;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          strt_glitch;
    logic          brk_obs;
`ifdef UART_RX_BREAK_DET_EN
    logic          break_det;
    assign brk_obs = break_det;
`else
    assign brk_obs = 1'b0;
`endif

    int            checks = 0;
    int            errors = 0;
    int unsigned   cyc = 0;
    int            presc = 8;
    exp_t          exp_q[$];
    int unsigned   dv_cyc[$];
    logic [DW-1:0] pdata_model = '0;
    exp_t          m_e;
    logic [4:0]    m_obs;
    logic [DW-1:0] m_pd;

    uart_rx_frame_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .RX_IN           (RX_IN),
        .prescaler       (prescaler),
        .par_en          (par_en),
        .par_typ         (par_typ),
        .sampled_bit     (sampled_bit),
        .dat_sampling_en (dat_sampling_en),
        .edge_cnt        (edge_cnt),
        .P_DATA          (P_DATA),
        .data_valid      (data_valid),
        .par_err         (par_err),
        .stp_err         (stp_err),
        .strt_glitch     (strt_glitch)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .break_det       (break_det)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe cycle consumes one expected frame outcome
    always @(posedge clk) begin
        #1;
        if (rst && (data_valid || par_err || stp_err || strt_glitch || brk_obs)) begin
            m_obs = {data_valid, par_err, stp_err, strt_glitch, brk_obs};
            if (data_valid) dv_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got dv/pe/se/gl/brk=%b required=no strobe", m_obs);
            end else begin
                m_e  = exp_q.pop_front();
                m_pd = m_e.dv ? m_e.data : pdata_model;
                if (m_obs !== {m_e.dv, m_e.perr, m_e.serr, m_e.glitch, m_e.brk}) begin
                    errors++;
                    $display("FAIL strobes got dv/pe/se/gl/brk=%b required=%b", m_obs,
                             {m_e.dv, m_e.perr, m_e.serr, m_e.glitch, m_e.brk});
                end
                checks++;
                if (P_DATA !== m_pd) begin
                    errors++;
                    $display("FAIL p_data got=%h required=%h", P_DATA, m_pd);
                end
                if (m_e.dv) pdata_model = m_e.data;
            end
        end
    end

    // Global safety bound
    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input int p, input logic pe, input logic pt);
        @(negedge clk);
        presc     = p;
        prescaler = PW'(p);
        par_en    = pe;
        par_typ   = pt;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            RX_IN       = 1'b1;
            sampled_bit = 1'b1;
        end
    endtask

    // One bit on the line for presc cycles; the sampler's vote follows the line
    task automatic drive_bit(input logic b);
        repeat (presc) begin
            @(negedge clk);
            RX_IN       = b;
            sampled_bit = b;
        end
    endtask

    function automatic logic good_par(input logic [DW-1:0] d);
        return (^d) ^ par_typ;
    endfunction

    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop);
        exp_t e;
        e.perr   = par_en && (pbit != good_par(d));
        e.serr   = !stop;
        e.dv     = stop && !e.perr;
        e.glitch = 1'b0;
        e.brk    = BRK_EN && (d == '0) && (!par_en || !pbit) && !stop;
        e.data   = d;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < int'(DW); i++) drive_bit(d[i]);
        if (par_en) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        set_cfg(8, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({data_valid, par_err, stp_err, strt_glitch, brk_obs} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b required=00000",
                     {data_valid, par_err, stp_err, strt_glitch, brk_obs});
        end
        checks++;
        if (edge_cnt !== '0 || dat_sampling_en !== 1'b0 || P_DATA !== '0) begin
            errors++;
            $display("FAIL reset_outputs got edge=%0d en=%b pdata=%h required 0 0 00",
                     edge_cnt, dat_sampling_en, P_DATA);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (edge_cnt !== '0 || dat_sampling_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got edge=%0d en=%b required 0 0", edge_cnt, dat_sampling_en);
        end
    endtask

    task automatic test_basic();
        set_cfg(8, 1'b0, 1'b0);
        idle(2);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_missing got pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_parity();
        set_cfg(16, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(4);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL parity_missing got pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_double_err();
        set_cfg(8, 1'b1, 1'b1);
        idle(2);
        send_frame(8'h01, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h01, 1'b0, 1'b0);
        idle(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL double_err_missing got pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_start_glitch();
        exp_t        e;
        int unsigned t0;
        bit          found;
        set_cfg(8, 1'b0, 1'b0);
        idle(2);
        e = '0;
        e.glitch = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        RX_IN       = 1'b0;
        sampled_bit = 1'b0;
        @(posedge clk);
        #1;
        t0 = cyc;
        checks++;
        if (edge_cnt !== PW'(1) || dat_sampling_en !== 1'b1) begin
            errors++;
            $display("FAIL start_count got edge=%0d en=%b required 1 1", edge_cnt, dat_sampling_en);
        end
        @(negedge clk);
        @(negedge clk);
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4 * presc && !found; i++) begin
            @(posedge clk);
            #1;
            if (strt_glitch) begin
                found = 1'b1;
                checks++;
                if (cyc != t0 + 32'(presc) - 1) begin
                    errors++;
                    $display("FAIL glitch_time got=%0d required=%0d", cyc - t0, presc - 1);
                end
                checks++;
                if (dat_sampling_en !== 1'b0 || edge_cnt !== '0) begin
                    errors++;
                    $display("FAIL glitch_idle got en=%b edge=%0d required 0 0",
                             dat_sampling_en, edge_cnt);
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL glitch_timeout got no strt_glitch required one");
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_missing got pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        set_cfg(8, 1'b0, 1'b0);
        idle(2);
        dv_cyc.delete();
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        idle(6);
        checks++;
        if (dv_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got=%0d required=2", dv_cyc.size());
        end else begin
            checks++;
            if (dv_cyc[1] - dv_cyc[0] != 32'(10 * presc)) begin
                errors++;
                $display("FAIL b2b_spacing got=%0d required=%0d", dv_cyc[1] - dv_cyc[0], 10 * presc);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_missing got pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_frame();
        set_cfg(8, 1'b0, 1'b0);
        idle(2);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({data_valid, par_err, stp_err, strt_glitch, brk_obs} !== 5'b0 ||
            edge_cnt !== '0 || dat_sampling_en !== 1'b0 || P_DATA !== '0) begin
            errors++;
            $display("FAIL mid_reset got strobes=%b edge=%0d en=%b pdata=%h required all 0",
                     {data_valid, par_err, stp_err, strt_glitch, brk_obs},
                     edge_cnt, dat_sampling_en, P_DATA);
        end
        pdata_model = '0;
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(3);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_missing got pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_break();
        set_cfg(8, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h00, 1'b0, 1'b0);
        idle(4);
        set_cfg(8, 1'b0, 1'b0);
        idle(2);
        send_frame(8'h00, 1'b0, 1'b0);
        idle(4);
        send_frame(8'h80, 1'b0, 1'b0);
        idle(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL break_missing got pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        prescaler   = PW'(8);
        test_reset();
        test_basic();
        test_parity();
        test_double_err();
        test_start_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_break();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
